// File: rtl/mem_arb_pkg.sv
// Shared encodings and block geometry for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned BLOCK_OFFSET_W  = 4;
    localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned MEM_LATENCY     = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStore
    } arb_state_e;

    typedef enum logic {
        OwnerIcache,
        OwnerDcache
    } owner_e;

    // Byte offset of a 16-bit word within a block.
    function automatic logic [BLOCK_OFFSET_W-1:0] word_offset(input logic [WORD_IDX_W-1:0] idx);
        return {idx, 1'b0};
    endfunction

endpackage

// File: rtl/block_fill_seq.sv
// Block-fill sequencer: issues one read per cycle for a whole block and
// counts returning words, flagging the last one.
module block_fill_seq
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  active_i,
    input  logic [ADDR_W-1:0]     blk_addr_i,
    input  logic                  mem_data_valid_i,
    output logic                  issue_en_o,
    output logic [ADDR_W-1:0]     issue_addr_o,
    output logic                  fill_valid_o,
    output logic [WORD_IDX_W-1:0] fill_idx_o,
    output logic                  done_o
);

    localparam logic [WORD_IDX_W-1:0] LastIdx = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

    logic [WORD_IDX_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [WORD_IDX_W-1:0] recv_cnt_q, recv_cnt_d;
    logic                  issue_sat_q, issue_sat_d;

    always_comb begin
        issue_en_o   = active_i && !issue_sat_q;
        issue_addr_o = issue_en_o ? (blk_addr_i | ADDR_W'(word_offset(issue_cnt_q))) : '0;
        fill_valid_o = active_i && mem_data_valid_i;
        fill_idx_o   = fill_valid_o ? recv_cnt_q : '0;
        done_o       = fill_valid_o && (recv_cnt_q == LastIdx);

        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        issue_sat_d = issue_sat_q;
        if (done_o) begin
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            issue_sat_d = 1'b0;
        end else begin
            // The 3-bit issue counter holds at the last index; the flag stops issuing.
            if (issue_en_o) begin
                if (issue_cnt_q == LastIdx) begin
                    issue_sat_d = 1'b1;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            if (fill_valid_o) begin
                recv_cnt_d = recv_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            issue_sat_q <= 1'b0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            issue_sat_q <= issue_sat_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between I-cache and D-cache miss
// handlers: block fills for both, single-word write-through stores for D-cache.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_req_i,
    input  logic [ADDR_W-1:0]     ic_addr_i,
    output logic                  ic_grant_o,
    output logic                  ic_done_o,
    input  logic                  dc_req_i,
    input  logic                  dc_wr_i,
    input  logic [ADDR_W-1:0]     dc_addr_i,
    input  logic [DATA_W-1:0]     dc_wdata_i,
    output logic                  dc_grant_o,
    output logic                  dc_done_o,
    output logic                  fill_valid_o,
    output logic [WORD_IDX_W-1:0] fill_idx_o,
    output logic [DATA_W-1:0]     fill_data_o,
    output logic                  mem_en_o,
    output logic                  mem_wr_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic                  mem_data_valid_i
);

    localparam logic [ADDR_W-1:0] BlkMask = ~ADDR_W'((1 << BLOCK_OFFSET_W) - 1);

    arb_state_e        state_q;
    owner_e            owner_q, last_owner_q;
    logic [ADDR_W-1:0] blk_q;
    logic              ic_grant_q, dc_grant_q;

    logic                  dc_wins;
    logic                  is_store;
    logic                  seq_issue_en;
    logic [ADDR_W-1:0]     seq_issue_addr;
    logic                  seq_fill_valid;
    logic [WORD_IDX_W-1:0] seq_fill_idx;
    logic                  seq_done;

    // Round-robin only on contention: D-cache wins unless it owned the port last.
    assign dc_wins = dc_req_i && (!ic_req_i || (last_owner_q != OwnerDcache));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= OwnerIcache;
            last_owner_q <= OwnerIcache;
            blk_q        <= '0;
            ic_grant_q   <= 1'b0;
            dc_grant_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dc_wins) begin
                        owner_q    <= OwnerDcache;
                        dc_grant_q <= 1'b1;
                        blk_q      <= dc_addr_i & BlkMask;
                        state_q    <= dc_wr_i ? StStore : StFill;
                    end else if (ic_req_i) begin
                        owner_q    <= OwnerIcache;
                        ic_grant_q <= 1'b1;
                        blk_q      <= ic_addr_i & BlkMask;
                        state_q    <= StFill;
                    end
                end
                StStore: begin
                    state_q      <= StIdle;
                    last_owner_q <= OwnerDcache;
                    dc_grant_q   <= 1'b0;
                end
                StFill: begin
                    if (seq_done) begin
                        state_q      <= StIdle;
                        last_owner_q <= owner_q;
                        ic_grant_q   <= 1'b0;
                        dc_grant_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    block_fill_seq #(
        .ADDR_W (ADDR_W)
    ) u_fill_seq (
        .clk              (clk),
        .rst_n            (rst_n),
        .active_i         (state_q == StFill),
        .blk_addr_i       (blk_q),
        .mem_data_valid_i (mem_data_valid_i),
        .issue_en_o       (seq_issue_en),
        .issue_addr_o     (seq_issue_addr),
        .fill_valid_o     (seq_fill_valid),
        .fill_idx_o       (seq_fill_idx),
        .done_o           (seq_done)
    );

    always_comb begin
        is_store     = (state_q == StStore);
        mem_en_o     = is_store || seq_issue_en;
        mem_wr_o     = is_store;
        mem_addr_o   = is_store ? dc_addr_i : seq_issue_addr;
        mem_wdata_o  = is_store ? dc_wdata_i : '0;
        fill_valid_o = seq_fill_valid;
        fill_idx_o   = seq_fill_idx;
        fill_data_o  = seq_fill_valid ? mem_rdata_i : '0;
        ic_done_o    = seq_done && (owner_q == OwnerIcache);
        dc_done_o    = is_store || (seq_done && (owner_q == OwnerDcache));
        ic_grant_o   = ic_grant_q;
        dc_grant_o   = dc_grant_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req = 1'b0;
    logic [15:0] ic_addr = '0;
    logic        ic_grant, ic_done;
    logic        dc_req = 1'b0;
    logic        dc_wr = 1'b0;
    logic [15:0] dc_addr = '0;
    logic [15:0] dc_wdata = '0;
    logic        dc_grant, dc_done;
    logic        fill_valid;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_data_valid;
    logic        stray_v = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } store_t;

    logic [15:0] exp_addr_q[$];
    logic [18:0] exp_fill_q[$];
    store_t      exp_store_q[$];

    mem_port_arbiter u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ic_req_i         (ic_req),
        .ic_addr_i        (ic_addr),
        .ic_grant_o       (ic_grant),
        .ic_done_o        (ic_done),
        .dc_req_i         (dc_req),
        .dc_wr_i          (dc_wr),
        .dc_addr_i        (dc_addr),
        .dc_wdata_i       (dc_wdata),
        .dc_grant_o       (dc_grant),
        .dc_done_o        (dc_done),
        .fill_valid_o     (fill_valid),
        .fill_idx_o       (fill_idx),
        .fill_data_o      (fill_data),
        .mem_en_o         (mem_en),
        .mem_wr_o         (mem_wr),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_rdata_i      (mem_rdata),
        .mem_data_valid_i (mem_data_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data = address ^ 0x5A5A, returned MEM_LATENCY cycles later.
    logic [MEM_LATENCY-1:0] pipe_v;
    logic [15:0]            pipe_d [MEM_LATENCY];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) pipe_d[i] <= '0;
        end else begin
            pipe_v    <= {pipe_v[MEM_LATENCY-2:0], mem_en && !mem_wr};
            pipe_d[0] <= mem_addr ^ 16'h5A5A;
            for (int i = 1; i < MEM_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign mem_data_valid = pipe_v[MEM_LATENCY-1] || stray_v;
    assign mem_rdata      = stray_v ? 16'hDEAD : pipe_d[MEM_LATENCY-1];

    function automatic logic [57:0] all_outs();
        return {ic_grant, ic_done, dc_grant, dc_done, fill_valid, fill_idx, fill_data,
                mem_en, mem_wr, mem_addr, mem_wdata};
    endfunction

    // Follows one block fill from its first FILL cycle to the idle cycle after done.
    task automatic run_fill_txn(input bit is_dc, input logic [15:0] req_addr,
                                input int drop_at, input bit keep_req);
        logic [15:0] blk;
        logic [15:0] a;
        logic [18:0] f;
        int          first;
        int          issued;
        bit          seen_done;
        blk = req_addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(blk | 16'(2 * i));
            exp_fill_q.push_back({3'(i), (blk | 16'(2 * i)) ^ 16'h5A5A});
        end
        first = -1;
        issued = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(negedge clk);
            vectors++;
            if (ic_grant !== !is_dc || dc_grant !== is_dc) begin
                miscompares++;
                $display("FAIL grant: got ic=%b dc=%b, required ic=%b dc=%b",
                         ic_grant, dc_grant, !is_dc, is_dc);
            end
            if (mem_en) begin
                if (first < 0) first = cyc;
                issued++;
                vectors++;
                if (exp_addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_issue: got addr=%h, required no issue", mem_addr);
                end else begin
                    a = exp_addr_q.pop_front();
                    if (mem_addr !== a || mem_wr !== 1'b0) begin
                        miscompares++;
                        $display("FAIL issue_addr: got addr=%h wr=%b, required addr=%h wr=0",
                                 mem_addr, mem_wr, a);
                    end
                end
                if (issued == drop_at) begin
                    if (is_dc) dc_req = 1'b0;
                    else ic_req = 1'b0;
                end
            end
            if (fill_valid) begin
                vectors++;
                if (exp_fill_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_fill: got idx=%0d data=%h, required none",
                             fill_idx, fill_data);
                end else begin
                    f = exp_fill_q.pop_front();
                    if ({fill_idx, fill_data} !== f) begin
                        miscompares++;
                        $display("FAIL fill_word: got idx=%0d data=%h, required idx=%0d data=%h",
                                 fill_idx, fill_data, f[18:16], f[15:0]);
                    end
                end
            end
            if (ic_done || dc_done) begin
                seen_done = 1'b1;
                vectors++;
                if ({ic_done, dc_done} !== {!is_dc, is_dc}) begin
                    miscompares++;
                    $display("FAIL done_owner: got ic=%b dc=%b, required ic=%b dc=%b",
                             ic_done, dc_done, !is_dc, is_dc);
                end
                vectors++;
                if (cyc - first != 8 + MEM_LATENCY - 1) begin
                    miscompares++;
                    $display("FAIL fill_latency: got %0d cycles, required %0d",
                             cyc - first, 8 + MEM_LATENCY - 1);
                end
                vectors++;
                if (exp_addr_q.size() != 0 || exp_fill_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL fill_count: got %0d issues/%0d words left over, required 0/0",
                             exp_addr_q.size(), exp_fill_q.size());
                end
                if (!keep_req) begin
                    if (is_dc) dc_req = 1'b0;
                    else ic_req = 1'b0;
                end
            end
        end
        if (!seen_done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done in 40 cycles, required done");
            exp_addr_q.delete();
            exp_fill_q.delete();
            ic_req = 1'b0;
            dc_req = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (ic_grant !== 1'b0 || dc_grant !== 1'b0 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL turnaround: got ic_grant=%b dc_grant=%b mem_en=%b, required 0/0/0",
                     ic_grant, dc_grant, mem_en);
        end
    endtask

    task automatic test_reset();
        ic_req = 1'b1;
        dc_req = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h, required 0", all_outs());
        end
    endtask

    task automatic test_arbitration();
        ic_addr = 16'h4448;
        ic_req  = 1'b1;
        dc_addr = 16'h8884;
        dc_wr   = 1'b0;
        dc_req  = 1'b1;
        run_fill_txn(1'b1, 16'h8884, -1, 1'b1);
        run_fill_txn(1'b0, 16'h4448, -1, 1'b0);
        run_fill_txn(1'b1, 16'h8884, -1, 1'b0);
    endtask

    task automatic test_ic_fill();
        ic_addr = 16'h1234;
        ic_req  = 1'b1;
        run_fill_txn(1'b0, 16'h1234, -1, 1'b0);
    endtask

    task automatic test_store();
        store_t s;
        dc_addr  = 16'h00A2;
        dc_wdata = 16'hBEEF;
        dc_wr    = 1'b1;
        dc_req   = 1'b1;
        exp_store_q.push_back('{addr: 16'h00A2, data: 16'hBEEF});
        @(negedge clk);
        s = exp_store_q.pop_front();
        vectors++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {2'b11, s.addr, s.data}) begin
            miscompares++;
            $display("FAIL store_bus: got en=%b wr=%b addr=%h data=%h, required 1 1 %h %h",
                     mem_en, mem_wr, mem_addr, mem_wdata, s.addr, s.data);
        end
        vectors++;
        if ({dc_done, dc_grant, ic_done, ic_grant, fill_valid} !== 5'b11000) begin
            miscompares++;
            $display("FAIL store_handshake: got done=%b grant=%b ic_done=%b ic_grant=%b fv=%b, required 1 1 0 0 0",
                     dc_done, dc_grant, ic_done, ic_grant, fill_valid);
        end
        dc_req = 1'b0;
        dc_wr  = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_en, dc_grant, dc_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL store_release: got en=%b grant=%b done=%b, required 0 0 0",
                     mem_en, dc_grant, dc_done);
        end
    endtask

    task automatic test_stray_valid();
        stray_v = 1'b1;
        #1;
        vectors++;
        if ({fill_valid, fill_data, ic_done, dc_done} !== '0) begin
            miscompares++;
            $display("FAIL stray_fill: got fv=%b data=%h ic_done=%b dc_done=%b, required all 0",
                     fill_valid, fill_data, ic_done, dc_done);
        end
        @(negedge clk);
        stray_v = 1'b0;
        vectors++;
        if ({mem_en, ic_grant, dc_grant} !== 3'b000) begin
            miscompares++;
            $display("FAIL stray_state: got en=%b ic_grant=%b dc_grant=%b, required 0 0 0",
                     mem_en, ic_grant, dc_grant);
        end
    endtask

    task automatic test_req_drop();
        dc_addr = 16'h3C46;
        dc_wr   = 1'b0;
        dc_req  = 1'b1;
        run_fill_txn(1'b1, 16'h3C46, 4, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        bit hit;
        hit = 1'b0;
        ic_addr = 16'h7778;
        ic_req  = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (mem_en && mem_addr == 16'h777A) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reach_word5: got no issue of 777a, required one");
        end
        #1;
        rst_n  = 1'b0;
        ic_req = 1'b0;
        #1;
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %h, required 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL idle_after_abort: got %h, required 0", all_outs());
        end
        ic_req = 1'b1;
        run_fill_txn(1'b0, 16'h7778, -1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_arbitration();
        test_ic_fill();
        test_store();
        test_stray_valid();
        test_req_drop();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
